// File: rtl/nios_system_nios2_qsys_1_trace_drain_ctrl.sv
// +----------------------------------------------------------------------------+
// | nios_system_nios2_qsys_1_trace_drain_ctrl                                  |
// | Queues packed trace strobes and drains them as 10-bit beats + end marker.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module nios_system_nios2_qsys_1_trace_drain_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        dct_strobe,
  input  logic [29:0] dct_buffer,
  input  logic [3:0]  dct_count,
  input  logic        test_ending,
  output logic [9:0]  trc_data,
  output logic        trc_valid,
  input  logic        trc_ready,
  output logic        trc_last,
  output logic        flush_done,
  output logic [7:0]  drop_count,
  output logic [15:0] frame_count,
  output logic        err_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_MARK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]  occ_q, occ_d;
  logic [1:0]  idx_q, idx_d;
  logic        ending_q, ending_d;
  logic [7:0]  drop_count_q, drop_count_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        err_q, err_d;

  logic        w_accept, w_push, w_pop, w_beat, w_last_frame;
  logic [1:0]  w_cnt_in, w_head_cnt;
  logic [29:0] w_head_buf;
  logic [9:0]  w_frame;

  always_comb begin
    w_accept   = dct_strobe && enable && !ending_q && (dct_count != 4'd0);
    w_cnt_in   = (dct_count > 4'd3) ? 2'd3 : dct_count[1:0];
    w_head_buf = rd_ptr_q ? buf1_q : buf0_q;
    w_head_cnt = rd_ptr_q ? cnt1_q : cnt0_q;
    case (idx_q)
      2'd0:    w_frame = w_head_buf[9:0];
      2'd1:    w_frame = w_head_buf[19:10];
      default: w_frame = w_head_buf[29:20];
    endcase

    trc_valid  = (state_q == ST_EMIT) || (state_q == ST_MARK);
    trc_last   = (state_q == ST_MARK);
    flush_done = (state_q == ST_DONE);
    trc_data   = 10'd0;
    if (state_q == ST_EMIT) trc_data = w_frame;
    else if (state_q == ST_MARK) trc_data = 10'h3FF;

    w_beat       = trc_valid && trc_ready;
    w_last_frame = (state_q == ST_EMIT) && (idx_q == (w_head_cnt - 2'd1));
    w_pop        = w_beat && w_last_frame;
    // A full FIFO can still take a strobe when the head leaves in the same cycle.
    w_push       = w_accept && ((occ_q != 2'd2) || w_pop);
  end

  always_comb begin
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    ending_d      = ending_q | test_ending;
    err_d         = err_q | (w_accept && (dct_count > 4'd3));
    drop_count_d  = drop_count_q;

    if (w_push) begin
      if (wr_ptr_q) begin
        buf1_d = dct_buffer;
        cnt1_d = w_cnt_in;
      end else begin
        buf0_d = dct_buffer;
        cnt0_d = w_cnt_in;
      end
      wr_ptr_d = ~wr_ptr_q;
    end
    if (w_pop) rd_ptr_d = ~rd_ptr_q;

    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (w_accept && !w_push && (drop_count_q != 8'hFF))
      drop_count_d = drop_count_q + 8'd1;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    case (state_q)
      ST_IDLE: begin
        if (occ_q != 2'd0) begin
          state_d = ST_EMIT;
          idx_d   = 2'd0;
        end else if (ending_q) begin
          state_d = ST_MARK;
        end
      end
      ST_EMIT: begin
        if (w_beat) begin
          frame_count_d = frame_count_q + 16'd1;
          if (w_last_frame) begin
            idx_d   = 2'd0;
            // Chain straight into the next entry to keep one frame per cycle.
            state_d = (occ_d != 2'd0) ? ST_EMIT : ST_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_MARK: begin
        if (w_beat) state_d = ST_DONE;
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      buf0_q        <= 30'd0;
      buf1_q        <= 30'd0;
      cnt0_q        <= 2'd0;
      cnt1_q        <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
      idx_q         <= 2'd0;
      ending_q      <= 1'b0;
      drop_count_q  <= 8'd0;
      frame_count_q <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
      idx_q         <= idx_d;
      ending_q      <= ending_d;
      drop_count_q  <= drop_count_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
    end
  end

  assign drop_count  = drop_count_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_q;

endmodule

`default_nettype wire
